// File: rtl/alarm_uart_pkg.sv
// Constants and the receiver state encoding shared by the alarm system's UART receiver and transmitter.
package alarm_uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int SYNC_STAGES          = 2;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_e;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input. Both flops reset to RESET_VALUE.
module bit_sync #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_frame_receiver.sv
// 8N1 UART receiver: synchronizes RX, validates the start bit mid-bit, shifts data LSB-first,
// checks the stop bit and reports each frame with a one-cycle arrived or frameErr strobe.
module uart_frame_receiver
  import alarm_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 RX,
  output logic                 arrived,
  output logic [DATA_BITS-1:0] dataO,
  output logic                 frameErr
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_LAST  = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(SYNC_STAGES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_e            state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [IW-1:0]        idx, idx_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [DATA_BITS-1:0] data_next;
  logic                 arrived_next;
  logic                 err_next;

  bit_sync #(
    .RESET_VALUE(1'b1)
  ) rx_sync (
    .clk  (Clock),
    .rst_n(Reset),
    .d    (RX),
    .q    (rxs)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= WAIT_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      dataO    <= '0;
      arrived  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      idx      <= idx_next;
      shift    <= shift_next;
      dataO    <= data_next;
      arrived  <= arrived_next;
      frameErr <= err_next;
    end
  end

  // The synchronizer still shows its reset value for a couple of cycles after reset, so
  // WAIT_IDLE lets it flush before trusting a high rxs as a genuinely idle line.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    idx_next     = idx;
    shift_next   = shift;
    data_next    = dataO;
    arrived_next = 1'b0;
    err_next     = 1'b0;

    case (state)
      WAIT_IDLE: begin
        if (cnt != FLUSH_LAST) begin
          cnt_next = cnt + 1'b1;
        end else if (rxs) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end

      // The counter is seeded with 1 because the edge that sees rxs low is already one
      // cycle past the raw low sample; this centres every later sample point in its bit.
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          cnt_next   = CW'(1);
        end
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next = '0;
          if (!rxs) begin
            state_next = DATA;
            idx_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next        = '0;
          shift_next[idx] = rxs;
          if (idx == IDX_LAST) begin
            state_next = STOP;
          end else begin
            idx_next = idx + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (rxs) begin
            data_next    = shift;
            arrived_next = 1'b1;
            state_next   = IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      default: begin
        state_next = WAIT_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule
